// File: rtl/axi_pkg.sv
// Shared AXI definitions: default bus widths, burst/response encodings and a
// response classification helper used by the register slice.
package axi_pkg;

  localparam int unsigned AWIDTH   = 32;
  localparam int unsigned DWIDTH   = 32;
  localparam int unsigned IDWIDTH  = 4;
  localparam int unsigned LENWIDTH = 8;

  typedef logic [2:0] size_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam logic [1:0] AXI_BURST_FIXED    = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP     = 2'b10;
  localparam logic [1:0] AXI_BURST_RESERVED = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // True for the two error responses; OKAY/EXOKAY are both successes.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle (with AXI3 wid) and its manager/subordinate views.
//   manager     : drives AW/W/AR payload+valid, B/R ready
//   subordinate : drives AW/W/AR ready, B/R payload+valid
interface axi_if #(
  parameter int unsigned AWIDTH   = axi_pkg::AWIDTH,
  parameter int unsigned DWIDTH   = axi_pkg::DWIDTH,
  parameter int unsigned IDWIDTH  = axi_pkg::IDWIDTH,
  parameter int unsigned LENWIDTH = axi_pkg::LENWIDTH
);

  logic                  awvalid;
  logic                  awready;
  logic [IDWIDTH-1:0]    awid;
  logic [AWIDTH-1:0]     awaddr;
  logic [LENWIDTH-1:0]   awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;

  logic                  wvalid;
  logic                  wready;
  logic [IDWIDTH-1:0]    wid;
  logic [DWIDTH-1:0]     wdata;
  logic [DWIDTH/8-1:0]   wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [IDWIDTH-1:0]    bid;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [IDWIDTH-1:0]    arid;
  logic [AWIDTH-1:0]     araddr;
  logic [LENWIDTH-1:0]   arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;

  logic                  rvalid;
  logic                  rready;
  logic [IDWIDTH-1:0]    rid;
  logic [DWIDTH-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport manager (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    input  awready,
    output wvalid, wid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport subordinate (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    output awready,
    input  wvalid, wid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

endinterface

// File: rtl/axi_skid_buf.sv
// Generic 2-entry valid/ready register slice. All outputs are registered, so
// no combinational path exists between the two sides.
//   clk, rst                   : clock, async active-high reset
//   in_valid/in_ready/in_data  : upstream side
//   out_valid/out_ready/out_data : downstream side
module axi_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             main_valid_d;
  logic [WIDTH-1:0] main_data_d;
  logic             skid_valid_d;
  logic [WIDTH-1:0] skid_data_d;
  logic             in_hs;
  logic             out_hs;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Next state. in_ready is !skid_valid outside reset, so the skid register is
  // never written while it already holds a beat.
  always_comb begin
    main_valid_d = out_valid;
    main_data_d  = out_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (skid_valid) begin
      if (out_hs) begin
        main_data_d  = skid_data;
        skid_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      if (!out_valid || out_ready) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (out_hs) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers; ready is held low through reset and rises one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= main_valid_d;
      out_data   <= main_data_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      in_ready   <= !skid_valid_d;
    end
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({in_valid, out_ready}));
  a_data_known: assert property (@(posedge clk) disable iff (rst)
    in_valid |-> !$isunknown(in_data));
  a_in_hold: assert property (@(posedge clk) disable iff (rst)
    in_valid && !in_ready |=> in_valid && $stable(in_data));
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> out_valid && $stable(out_data));

endmodule

// File: rtl/axi_modport_slice.sv
// AXI4 register slice: every channel goes through a 2-entry skid buffer.
// Also reports sticky B/R error flags and outstanding write/read counts.
//   i_aclk, i_arst        : clock, async active-high reset
//   s_axi                 : upstream (faces the manager)
//   m_axi                 : downstream (faces the subordinate)
//   o_b_err, o_r_err      : sticky error-response flags, cleared by i_err_clr
//   o_wr_ostd, o_rd_ostd  : saturating outstanding-transaction counters
module axi_modport_slice #(
  parameter int unsigned AWIDTH   = axi_pkg::AWIDTH,
  parameter int unsigned DWIDTH   = axi_pkg::DWIDTH,
  parameter int unsigned IDWIDTH  = axi_pkg::IDWIDTH,
  parameter int unsigned LENWIDTH = axi_pkg::LENWIDTH,
  parameter int unsigned OSTDW    = 4
) (
  input  logic             i_aclk,
  input  logic             i_arst,
  axi_if.subordinate       s_axi,
  axi_if.manager           m_axi,
  output logic             o_b_err,
  output logic             o_r_err,
  input  logic             i_err_clr,
  output logic [OSTDW-1:0] o_wr_ostd,
  output logic [OSTDW-1:0] o_rd_ostd
);

  import axi_pkg::*;

  localparam int unsigned AX_W = IDWIDTH + AWIDTH + LENWIDTH + 13;
  localparam int unsigned W_W  = IDWIDTH + DWIDTH + DWIDTH / 8 + 1;
  localparam int unsigned B_W  = IDWIDTH + 2;
  localparam int unsigned R_W  = IDWIDTH + DWIDTH + 3;
  localparam logic [OSTDW-1:0] OSTD_MAX = '1;

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;

  logic aw_hs, ar_hs, b_hs, r_hs, rlast_hs;

  // Channel payload packing (everything except valid/ready).
  assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize,
                  s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot};
  assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize,
          m_axi.awburst, m_axi.awlock, m_axi.awcache, m_axi.awprot} = aw_out;

  assign w_in = {s_axi.wid, s_axi.wdata, s_axi.wstrb, s_axi.wlast};
  assign {m_axi.wid, m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_out;

  assign b_in = {m_axi.bid, m_axi.bresp};
  assign {s_axi.bid, s_axi.bresp} = b_out;

  assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize,
                  s_axi.arburst, s_axi.arlock, s_axi.arcache, s_axi.arprot};
  assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize,
          m_axi.arburst, m_axi.arlock, m_axi.arcache, m_axi.arprot} = ar_out;

  assign r_in = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast};
  assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast} = r_out;

  axi_skid_buf #(.WIDTH(AX_W)) u_aw (
    .clk(i_aclk), .rst(i_arst),
    .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
    .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out));

  axi_skid_buf #(.WIDTH(W_W)) u_w (
    .clk(i_aclk), .rst(i_arst),
    .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
    .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out));

  axi_skid_buf #(.WIDTH(B_W)) u_b (
    .clk(i_aclk), .rst(i_arst),
    .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
    .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out));

  axi_skid_buf #(.WIDTH(AX_W)) u_ar (
    .clk(i_aclk), .rst(i_arst),
    .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
    .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out));

  axi_skid_buf #(.WIDTH(R_W)) u_r (
    .clk(i_aclk), .rst(i_arst),
    .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
    .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out));

  // Counters and flags observe the upstream side only.
  assign aw_hs    = s_axi.awvalid && s_axi.awready;
  assign ar_hs    = s_axi.arvalid && s_axi.arready;
  assign b_hs     = s_axi.bvalid && s_axi.bready;
  assign r_hs     = s_axi.rvalid && s_axi.rready;
  assign rlast_hs = r_hs && s_axi.rlast;

  // Saturating outstanding counters; simultaneous inc/dec leaves them unchanged.
  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      o_wr_ostd <= '0;
      o_rd_ostd <= '0;
    end else begin
      if (aw_hs && !b_hs && (o_wr_ostd != OSTD_MAX)) o_wr_ostd <= o_wr_ostd + OSTDW'(1);
      else if (b_hs && !aw_hs && (o_wr_ostd != '0))  o_wr_ostd <= o_wr_ostd - OSTDW'(1);
      if (ar_hs && !rlast_hs && (o_rd_ostd != OSTD_MAX)) o_rd_ostd <= o_rd_ostd + OSTDW'(1);
      else if (rlast_hs && !ar_hs && (o_rd_ostd != '0))  o_rd_ostd <= o_rd_ostd - OSTDW'(1);
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      o_b_err <= 1'b0;
      o_r_err <= 1'b0;
    end else begin
      o_b_err <= (b_hs && resp_is_err(s_axi.bresp)) || (o_b_err && !i_err_clr);
      o_r_err <= (r_hs && resp_is_err(s_axi.rresp)) || (o_r_err && !i_err_clr);
    end
  end

  a_awburst_ok: assert property (@(posedge i_aclk) disable iff (i_arst)
    s_axi.awvalid |-> (s_axi.awburst != AXI_BURST_RESERVED));
  a_arburst_ok: assert property (@(posedge i_aclk) disable iff (i_arst)
    s_axi.arvalid |-> (s_axi.arburst != AXI_BURST_RESERVED));

endmodule

// File: tb/tb_axi_modport_slice.sv
// Directed bench for axi_modport_slice plus a randomised W-channel scoreboard run.
module tb_axi_modport_slice;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic       b_err, r_err;
  logic [3:0] wr_ostd, rd_ostd;

  int checks = 0;
  int errors = 0;

  axi_if s_bus ();
  axi_if m_bus ();

  axi_modport_slice dut (
    .i_aclk   (clk),
    .i_arst   (rst),
    .s_axi    (s_bus),
    .m_axi    (m_bus),
    .o_b_err  (b_err),
    .o_r_err  (r_err),
    .i_err_clr(err_clr),
    .o_wr_ostd(wr_ostd),
    .o_rd_ostd(rd_ostd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: the edge happens, then outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [40:0] q[$];
  logic [40:0] exp_beat;
  logic        in_hs, out_hs;
  int          sent, rcvd;

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    s_bus.awvalid = 0; s_bus.awid = 0; s_bus.awaddr = 0; s_bus.awlen = 0; s_bus.awsize = 0;
    s_bus.awburst = 0; s_bus.awlock = 0; s_bus.awcache = 0; s_bus.awprot = 0;
    s_bus.wvalid = 0; s_bus.wid = 0; s_bus.wdata = 0; s_bus.wstrb = 0; s_bus.wlast = 0;
    s_bus.bready = 0;
    s_bus.arvalid = 0; s_bus.arid = 0; s_bus.araddr = 0; s_bus.arlen = 0; s_bus.arsize = 0;
    s_bus.arburst = 0; s_bus.arlock = 0; s_bus.arcache = 0; s_bus.arprot = 0;
    s_bus.rready = 0;
    m_bus.awready = 0; m_bus.wready = 0; m_bus.arready = 0;
    m_bus.bvalid = 0; m_bus.bid = 0; m_bus.bresp = 0;
    m_bus.rvalid = 0; m_bus.rid = 0; m_bus.rdata = 0; m_bus.rresp = 0; m_bus.rlast = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", 64'(s_bus.awready), 64'(0));
    chk("rst_wready",  64'(s_bus.wready),  64'(0));
    chk("rst_arready", 64'(s_bus.arready), 64'(0));
    chk("rst_bready",  64'(m_bus.bready),  64'(0));
    chk("rst_m_awvalid", 64'(m_bus.awvalid), 64'(0));
    chk("rst_s_rvalid",  64'(s_bus.rvalid),  64'(0));
    chk("rst_wr_ostd", 64'(wr_ostd), 64'(0));
    chk("rst_rd_ostd", 64'(rd_ostd), 64'(0));
    rst = 1'b0;
    s_bus.bready = 1; s_bus.rready = 1;
    m_bus.awready = 1; m_bus.wready = 1; m_bus.arready = 1;
    chk("rel_awready_still0", 64'(s_bus.awready), 64'(0));
    step();
    chk("rel_awready", 64'(s_bus.awready), 64'(1));
    chk("rel_wready",  64'(s_bus.wready),  64'(1));
    chk("rel_rready",  64'(m_bus.rready),  64'(1));

    // Single write
    s_bus.awvalid = 1; s_bus.awid = 4'd3; s_bus.awaddr = 32'h100; s_bus.awlen = 8'd0;
    s_bus.awsize = 3'd2; s_bus.awburst = 2'b01;
    step();
    s_bus.awvalid = 0;
    chk("wr_m_awvalid", 64'(m_bus.awvalid), 64'(1));
    chk("wr_m_awaddr",  64'(m_bus.awaddr),  64'h100);
    chk("wr_m_awid",    64'(m_bus.awid),    64'(3));
    chk("wr_m_awburst", 64'(m_bus.awburst), 64'(1));
    chk("wr_ostd_1",    64'(wr_ostd),       64'(1));
    s_bus.wvalid = 1; s_bus.wid = 4'd3; s_bus.wdata = 32'hDEADBEEF; s_bus.wstrb = 4'hF; s_bus.wlast = 1;
    step();
    s_bus.wvalid = 0;
    chk("wr_m_awvalid_done", 64'(m_bus.awvalid), 64'(0));
    chk("wr_m_wvalid", 64'(m_bus.wvalid), 64'(1));
    chk("wr_m_wdata",  64'(m_bus.wdata),  64'hDEADBEEF);
    chk("wr_m_wstrb",  64'(m_bus.wstrb),  64'hF);
    m_bus.bvalid = 1; m_bus.bid = 4'd3; m_bus.bresp = 2'b00;
    step();
    m_bus.bvalid = 0;
    chk("wr_s_bvalid", 64'(s_bus.bvalid), 64'(1));
    chk("wr_s_bid",    64'(s_bus.bid),    64'(3));
    chk("wr_s_bresp",  64'(s_bus.bresp),  64'(0));
    chk("wr_ostd_still1", 64'(wr_ostd), 64'(1));
    step();
    chk("wr_ostd_0", 64'(wr_ostd), 64'(0));
    chk("wr_s_bvalid_done", 64'(s_bus.bvalid), 64'(0));
    chk("wr_b_err", 64'(b_err), 64'(0));

    // Read burst of 4
    s_bus.arvalid = 1; s_bus.arid = 4'd5; s_bus.araddr = 32'h200; s_bus.arlen = 8'd3;
    s_bus.arsize = 3'd2; s_bus.arburst = 2'b01;
    step();
    s_bus.arvalid = 0;
    chk("rd_m_arvalid", 64'(m_bus.arvalid), 64'(1));
    chk("rd_m_araddr",  64'(m_bus.araddr),  64'h200);
    chk("rd_m_arlen",   64'(m_bus.arlen),   64'(3));
    chk("rd_ostd_1",    64'(rd_ostd),       64'(1));
    step();
    for (int i = 0; i < 4; i++) begin
      m_bus.rvalid = 1; m_bus.rid = 4'd5; m_bus.rdata = 32'hA0 + 32'(i);
      m_bus.rresp = 2'b00; m_bus.rlast = (i == 3);
      chk("rd_m_rready", 64'(m_bus.rready), 64'(1));
      step();
      chk("rd_s_rvalid", 64'(s_bus.rvalid), 64'(1));
      chk("rd_s_rdata",  64'(s_bus.rdata),  64'h0A0 + 64'(i));
      chk("rd_s_rlast",  64'(s_bus.rlast),  64'(i == 3));
      chk("rd_ostd_mid", 64'(rd_ostd),      64'(1));
    end
    m_bus.rvalid = 0; m_bus.rlast = 0;
    step();
    chk("rd_ostd_0", 64'(rd_ostd), 64'(0));
    chk("rd_s_rvalid_done", 64'(s_bus.rvalid), 64'(0));

    // W backpressure: two beats held, third waits upstream
    m_bus.wready = 0;
    s_bus.wvalid = 1; s_bus.wid = 4'd2; s_bus.wdata = 32'h11; s_bus.wstrb = 4'hF; s_bus.wlast = 0;
    step();
    s_bus.wdata = 32'h22;
    step();
    chk("bp_wready_low", 64'(s_bus.wready), 64'(0));
    s_bus.wdata = 32'h33; s_bus.wlast = 1;
    step();
    chk("bp_wready_held", 64'(s_bus.wready), 64'(0));
    chk("bp_m_wvalid", 64'(m_bus.wvalid), 64'(1));
    chk("bp_beat0",    64'(m_bus.wdata),  64'h11);
    m_bus.wready = 1;
    step();
    chk("bp_beat1",    64'(m_bus.wdata),  64'h22);
    chk("bp_wready_back", 64'(s_bus.wready), 64'(1));
    step();
    s_bus.wvalid = 0; s_bus.wlast = 0;
    chk("bp_beat2",    64'(m_bus.wdata),  64'h33);
    chk("bp_beat2_last", 64'(m_bus.wlast), 64'(1));
    step();
    chk("bp_drained", 64'(m_bus.wvalid), 64'(0));

    // Error flags
    m_bus.rvalid = 1; m_bus.rid = 4'd1; m_bus.rdata = 32'h0; m_bus.rresp = 2'b10; m_bus.rlast = 1;
    step();
    m_bus.rvalid = 0;
    chk("err_r_not_yet", 64'(r_err), 64'(0));
    step();
    chk("err_r_set", 64'(r_err), 64'(1));
    chk("err_rd_ostd_floor", 64'(rd_ostd), 64'(0));
    step();
    chk("err_r_sticky", 64'(r_err), 64'(1));
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_r_cleared", 64'(r_err), 64'(0));
    m_bus.rvalid = 1; m_bus.rresp = 2'b11;
    step();
    m_bus.rvalid = 0; err_clr = 1;
    step();
    err_clr = 0;
    chk("err_r_set_wins", 64'(r_err), 64'(1));
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_r_cleared2", 64'(r_err), 64'(0));
    m_bus.bvalid = 1; m_bus.bid = 4'd2; m_bus.bresp = 2'b01;
    step();
    m_bus.bvalid = 0;
    step();
    chk("err_b_exokay", 64'(b_err), 64'(0));
    chk("err_wr_ostd_floor", 64'(wr_ostd), 64'(0));
    m_bus.bvalid = 1; m_bus.bresp = 2'b11;
    step();
    m_bus.bvalid = 0;
    step();
    chk("err_b_decerr", 64'(b_err), 64'(1));
    chk("err_r_indep",  64'(r_err), 64'(0));

    // Counter saturation and simultaneous inc/dec
    m_bus.bresp = 2'b00;
    s_bus.awvalid = 1;
    repeat (16) step();
    s_bus.awvalid = 0;
    chk("sat_wr_ostd_max", 64'(wr_ostd), 64'(15));
    m_bus.bvalid = 1;
    step();
    m_bus.bvalid = 0;
    step();
    chk("sat_wr_ostd_dec", 64'(wr_ostd), 64'(14));
    m_bus.bvalid = 1;
    step();
    m_bus.bvalid = 0; s_bus.awvalid = 1;
    step();
    s_bus.awvalid = 0;
    chk("sat_wr_ostd_both", 64'(wr_ostd), 64'(14));
    step();

    // Random valid/ready on the W channel with an in-order scoreboard
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 4000 && rcvd < 300; cyc++) begin
      if (!s_bus.wvalid && sent < 300 && $urandom_range(0, 3) != 0) begin
        s_bus.wvalid = 1;
        s_bus.wid    = 4'($urandom);
        s_bus.wdata  = $urandom;
        s_bus.wstrb  = 4'($urandom);
        s_bus.wlast  = 1'($urandom);
      end
      m_bus.wready = ($urandom_range(0, 3) != 0);
      in_hs  = s_bus.wvalid && s_bus.wready;
      out_hs = m_bus.wvalid && m_bus.wready;
      if (in_hs) begin
        q.push_back({s_bus.wid, s_bus.wdata, s_bus.wstrb, s_bus.wlast});
        sent++;
      end
      if (out_hs) begin
        exp_beat = q.pop_front();
        chk("rand_w_beat", 64'({m_bus.wid, m_bus.wdata, m_bus.wstrb, m_bus.wlast}), 64'(exp_beat));
        rcvd++;
      end
      step();
      if (in_hs) s_bus.wvalid = 0;
    end
    chk("rand_w_count", 64'(rcvd), 64'(300));
    chk("rand_w_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
